// File: rtl/shift_counter_pkg.sv
// Shared encodings for the ring/Johnson shift counter sequencer.
// Mode constants and the sequencer FSM state type.
package shift_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_counter_core.sv
// Combinational next-value and seed-legality block for the shift counter.
// Shifts q in the run mode, and validates/repairs a seed in the command mode.
module shift_counter_core
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             run_mode,
    input  logic [WIDTH-1:0] q,
    input  logic             seed_mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] next_q,
    output logic             seed_legal,
    output logic [WIDTH-1:0] seed_fixed
);

    int transitions;

    // NOTE: every combinational output is given a default before any branch so no latch is inferred.
    always_comb begin
        next_q      = {q[WIDTH-2:0], q[WIDTH-1]};
        transitions = 0;
        seed_legal  = 1'b1;
        seed_fixed  = seed;

        if (run_mode == MODE_JOHNSON) begin
            next_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
        end

        // A Johnson code has at most one boundary between its 0-run and 1-run.
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (seed[i] != seed[i+1]) begin
                transitions = transitions + 1;
            end
        end

        if (seed_mode == MODE_RING) begin
            seed_legal = |seed;
            if (!seed_legal) begin
                seed_fixed = {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            seed_legal = (transitions <= 1);
            if (!seed_legal) begin
                seed_fixed = '0;
            end
        end
    end

endmodule

// File: rtl/shift_counter_ctrl.sv
// Command-driven sequencer for a ring/Johnson shift counter.
// Loads a (repaired) seed, shifts the requested steps, flags wrap and completion.
module shift_counter_ctrl
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_seed,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err_fixed
);

    state_t           state, state_next;
    logic [WIDTH-1:0] start;
    logic [CNT_W-1:0] remaining;
    logic             mode;

    logic             load, shift, done_d, wrap_d, err_d;
    logic [WIDTH-1:0] next_q, seed_fixed;
    logic             seed_legal;

    shift_counter_core #(.WIDTH(WIDTH)) u_core (
        .run_mode   (mode),
        .q          (q),
        .seed_mode  (cmd_mode),
        .seed       (cmd_seed),
        .next_q     (next_q),
        .seed_legal (seed_legal),
        .seed_fixed (seed_fixed)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        done_d     = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    load       = 1'b1;
                    state_next = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!hold) begin
                    shift = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Abort wins over the completion pulse.
                state_next = IDLE;
                done_d     = !abort;
            end
            default: state_next = IDLE;
        endcase

        wrap_d = shift && (next_q == start);
        err_d  = load && !seed_legal;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            start     <= '0;
            remaining <= '0;
            mode      <= MODE_RING;
            done      <= 1'b0;
            wrap      <= 1'b0;
            err_fixed <= 1'b0;
        end else begin
            done      <= done_d;
            wrap      <= wrap_d;
            err_fixed <= err_d;
            if (load) begin
                q         <= seed_fixed;
                start     <= seed_fixed;
                mode      <= cmd_mode;
                remaining <= cmd_steps;
            end else if (shift) begin
                q         <= next_q;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_counter_ctrl.sv
// Directed self-checking bench for shift_counter_ctrl (WIDTH=4, CNT_W=8).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_shift_counter_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_mode = 1'b0;
    logic [WIDTH-1:0] cmd_seed = '0;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic             hold = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy, done, wrap, err_fixed;

    int checks = 0;
    int failures = 0;

    shift_counter_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_seed  (cmd_seed),
        .cmd_steps (cmd_steps),
        .hold      (hold),
        .abort     (abort),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err_fixed (err_fixed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic mode, input logic [WIDTH-1:0] seed, input logic [CNT_W-1:0] steps);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_seed  = seed;
        cmd_steps = steps;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] ring_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [WIDTH-1:0] john_exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                       4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        // Reset state
        tick();
        check("rst_q", q, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrap, 0);
        check("rst_err", err_fixed, 0);
        rst = 1'b0;
        tick();
        check("rst_ready", cmd_ready, 1);

        // 1: ring 0001, 4 steps
        send_cmd(1'b0, 4'b0001, 8'd4);
        check("c1_load_q", q, 4'b0001);
        check("c1_busy", busy, 1);
        check("c1_ready", cmd_ready, 0);
        check("c1_err", err_fixed, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("c1_q%0d", i), q, ring_exp[i]);
            check($sformatf("c1_wrap%0d", i), wrap, (i == 3) ? 1 : 0);
            check($sformatf("c1_nodone%0d", i), done, 0);
        end
        tick();
        check("c1_done", done, 1);
        check("c1_ready_after", cmd_ready, 1);
        check("c1_wrap_clear", wrap, 0);
        tick();
        check("c1_done_pulse", done, 0);

        // 2: Johnson 0000, 8 steps
        send_cmd(1'b1, 4'b0000, 8'd8);
        check("c2_load_q", q, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("c2_q%0d", i), q, john_exp[i]);
            check($sformatf("c2_wrap%0d", i), wrap, (i == 7) ? 1 : 0);
            check($sformatf("c2_nodone%0d", i), done, 0);
        end
        tick();
        check("c2_done", done, 1);
        tick();
        check("c2_done_pulse", done, 0);

        // 3: seed repair
        send_cmd(1'b0, 4'b0000, 8'd0);
        check("c3_ring_q", q, 4'b0001);
        check("c3_ring_err", err_fixed, 1);
        tick();
        check("c3_ring_err_pulse", err_fixed, 0);
        check("c3_ring_done", done, 1);
        send_cmd(1'b1, 4'b0101, 8'd0);
        check("c3_john_q", q, 4'b0000);
        check("c3_john_err", err_fixed, 1);
        tick();
        send_cmd(1'b1, 4'b1100, 8'd0);
        check("c3_legal_q", q, 4'b1100);
        check("c3_legal_err", err_fixed, 0);
        tick();

        // 4: zero steps
        send_cmd(1'b0, 4'b1010, 8'd0);
        check("c4_q", q, 4'b1010);
        check("c4_nodone", done, 0);
        tick();
        check("c4_done", done, 1);
        check("c4_q_hold", q, 4'b1010);
        check("c4_wrap", wrap, 0);
        tick();

        // 5: hold for two cycles after the first shift
        send_cmd(1'b0, 4'b0001, 8'd4);
        tick();
        check("c5_q1", q, 4'b0010);
        hold = 1'b1;
        cmd_valid = 1'b1;
        cmd_seed  = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("c5_ready%0d", i), cmd_ready, 0);
            tick();
            check($sformatf("c5_held_q%0d", i), q, 4'b0010);
            check($sformatf("c5_held_wrap%0d", i), wrap, 0);
        end
        hold = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("c5_q%0d", i), q, ring_exp[i]);
            check($sformatf("c5_nodone%0d", i), done, 0);
        end
        check("c5_wrap", wrap, 1);
        tick();
        check("c5_done", done, 1);
        tick();

        // 6a: abort after two shifts
        send_cmd(1'b0, 4'b0001, 8'd4);
        tick();
        tick();
        check("c6_q2", q, 4'b0100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("c6_abort_q", q, 4'b0100);
        check("c6_abort_busy", busy, 0);
        check("c6_abort_ready", cmd_ready, 1);
        check("c6_abort_nodone", done, 0);
        tick();
        check("c6_abort_q_frozen", q, 4'b0100);
        check("c6_abort_nodone2", done, 0);

        // 6b: asynchronous reset mid-run
        send_cmd(1'b0, 4'b0001, 8'd4);
        tick();
        tick();
        check("c6_pre_rst_q", q, 4'b0100);
        #2 rst = 1'b1;
        #1;
        check("c6_async_q", q, 0);
        check("c6_async_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        check("c6_post_rst_ready", cmd_ready, 1);
        check("c6_post_rst_q", q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_counter_ctrl.md
Name: shift_counter_ctrl

Overview:
Sequencer for a parameterised shift counter that runs in ring or Johnson (twisted-ring) mode. It accepts a command (mode, seed, step count) over a valid/ready handshake, loads the seed and shifts the requested number of steps. It supports hold and abort, repairs illegal seeds, and flags period wrap and completion. It sits between a host/control FSM and any logic that consumes one-hot or Johnson phase codes, such as phase sequencers and stepper drive.

Parameters:
WIDTH, 4, counter width in bits (≥2)
CNT_W, 8, width of step-count field

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command (IDLE only)
cmd_mode  in  1  0 = ring, 1 = Johnson
cmd_seed  in  WIDTH  initial counter value
cmd_steps  in  CNT_W  number of shifts to perform (0 allowed)
hold  in  1  freeze shifting while in RUN
abort  in  1  terminate current run
q  out  WIDTH  counter value
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at normal completion
wrap  out  1  one-cycle pulse when q returns to the loaded start value
err_fixed  out  1  one-cycle pulse when the seed was repaired at load

Behaviour:
- Reset (async, any time, including mid-run): state = IDLE, q = 0, internal start/remaining/mode = 0, busy = done = wrap = err_fixed = 0. cmd_ready = 1 once reset deasserts.
- FSM states are IDLE, RUN and DONE. Outputs are registered, except cmd_ready = (state == IDLE) and busy = (state != IDLE).
- IDLE, on cmd_valid && cmd_ready (accept at edge T):
  - q <= fixed seed; start <= fixed seed; mode and remaining <= cmd_steps are latched.
  - err_fixed <= 1 if the seed was repaired.
  - Next state is RUN, or DONE if cmd_steps == 0.
  - q = seed is visible after T. The first shift occurs at T+1 at the earliest.
- Seed repair:
  - Ring mode: a seed of all-zero is replaced with 1 (LSB set). Other seeds, including multi-hot, are used as-is.
  - Johnson mode: the seed is legal only if it has at most one transition between adjacent bits (patterns 0…01…1 or 1…10…0). An illegal seed is replaced with 0.
- RUN, with abort == 0 and hold == 0, at each edge:
  - Ring mode: q <= {q[WIDTH-2:0], q[WIDTH-1]} (rotate left).
  - Johnson mode: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - remaining <= remaining − 1. If remaining == 1, next state is DONE.
  - wrap <= 1 when the next q equals start (period WIDTH for ring, 2·WIDTH for Johnson).
- RUN with hold == 1: q, remaining and state are unchanged; wrap = 0.
- DONE: done <= 1 for exactly one cycle, then IDLE. q holds its final value until the next accept.
- Latency: accept → done pulse is cmd_steps + 1 cycles with no hold; each held cycle adds one.
- Abort (priority over hold) in RUN or DONE: next state is IDLE, q is frozen at its current value, and no done pulse is produced. Abort in IDLE has no effect. Abort has priority over a same-cycle done: done is suppressed.
- cmd_valid is ignored unless cmd_ready is high. The command fields must be stable only at the accept edge.
- All pulses (done, wrap, err_fixed) are low in all other cycles.

Decomposition:
- Package shift_counter_pkg holds:
  - the mode encoding constants MODE_RING = 1'b0 and MODE_JOHNSON = 1'b1;
  - the FSM state enum (IDLE, RUN, DONE).
- One sub-module, shift_counter_core: a combinational next-value and seed-legality function block (mode, q/seed → next_q, legal). The FSM, counters and flags live in the top level.

Test Plan:
1. Ring mode, seed 0001, steps 4, WIDTH = 4 → q = 0001, 0010, 0100, 1000, 0001 on successive cycles. wrap is high with the final 0001. done pulses the next cycle, then cmd_ready = 1.
2. Johnson mode, seed 0000, steps 8 → q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. wrap is high only on the 8th shift. done fires once.
3. Illegal seeds: ring 0000 → err_fixed pulse, q = 0001. Johnson 0101 → err_fixed pulse, q = 0000. Legal Johnson seed 1100 → no err_fixed.
4. steps = 0, seed 1010 in ring mode → q = 1010 and no shift. done pulses one cycle after accept; wrap = 0.
5. Ring mode, seed 0001, steps 4, hold high for 2 cycles after the first shift → q sits at 0010 for 2 cycles. done arrives 2 cycles later than in case 1. cmd_valid pulsed during the run is not accepted (cmd_ready = 0).
6. Abort after 2 shifts → q frozen at 0100, IDLE next cycle, no done. A separate run with async rst asserted mid-RUN → q = 0, busy = 0 immediately, without waiting for a clock edge.
